datapath2: RTL and testbench
============================

DATAPATH2 -- requirements
Module: datapath2

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high: clk input 1, rising-edge clock; clr input 1, asynchronous active-high reset.
REQ-002 SHALL have these register-enable inputs, 1 bit each, active-high, sampled at rising clk: PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin, OutportIn.
REQ-003 SHALL have these bus-drive inputs, 1 bit each: PCout, Zlowout, MDRout, MBIout (manualBusInput), Rout, BAout, Cout.
REQ-004 SHALL have register-select inputs Gra, Grb, Grc, 1 bit each, selecting IR field Ra, Rb or Rc respectively.
REQ-005 SHALL have memory-control inputs Read and Write, 1 bit each.
REQ-006 SHALL have input OpCode, 5 bits, ALU operation select.
REQ-007 SHALL have input manualBusInput, 32 bits, external value driven onto the bus when MBIout=1.
REQ-008 SHALL have outputs BusMuxOut (32 bits, current bus value), CON (1 bit, branch flag) and OutportData (32 bits, output port register).

Function
REQ-009 SHALL hold these registers: PC, IR, MAR, MDR, Y and Z (32 bits each), R0-R15 (32 bits each), CON (1 bit), Outport (32 bits), and a 512x32 RAM.
REQ-010 SHALL drive BusMuxOut by fixed priority MBIout > MDRout > PCout > Zlowout > Cout > Rout/BAout, and drive 0 when no source is asserted.
REQ-011 SHALL decode IR as opcode[31:27], Ra[26:23], Rb[22:19], Rc[18:15] and C[18:0]; Cout SHALL drive C sign-extended from bit 18.
REQ-012 SHALL form the selected register index as OR of (Gra&Ra, Grb&Rb, Grc&Rc).
REQ-013 SHALL write the bus into the selected register on Rin.
REQ-014 SHALL drive the selected register on Rout or BAout; under BAout, a selected R0 SHALL read as 0, while under Rout it SHALL read its stored contents.
REQ-015 SHALL compute ALU A from Y and B from the bus, combinationally, with this OpCode map:
- 2 add
- 3 sub (A-B)
- 4 and
- 5 or
- 6 shr (logical, B[4:0])
- 7 shl
- 8 ror
- 9 rol
- 10 neg B
- 11 not B
- 12 inc B+1
- any other code 0
REQ-016 SHALL latch the ALU result into Z on Zin; arithmetic SHALL be mod 2^32, with carries discarded.
REQ-017 SHALL load MAR from the bus on MARin; RAM SHALL be addressed by MAR[8:0].
REQ-018 SHALL load MDR on MDRin from RAM[MAR] (asynchronous read) when Read=1, otherwise from the bus.
REQ-019 SHALL write MDR into RAM[MAR] at rising clk when Write=1; when MDRin and Write are both asserted, RAM SHALL receive the pre-edge MDR value.
REQ-020 SHALL set CON from the bus on CONin using IR[20:19]: 00 bus==0, 01 bus!=0, 10 bus[31]==0 and bus!=0, 11 bus[31]==1.
REQ-021 SHALL load PC and IR from the bus on PCin and IRin respectively.

Reset
REQ-022 SHALL, on clr=1, immediately clear PC, IR, MAR, MDR, Y, Z, R0-R15, CON and Outport to 0, regardless of clk; RAM contents SHALL be unaffected.
REQ-023 SHALL, after release, take its first register update at the next rising clk.

Configuration
REQ-024 SHALL compile the output port only when DATAPATH2_OUTPORT_EN is defined; Outport then loads from the bus on OutportIn.
REQ-025 SHALL, when DATAPATH2_OUTPORT_EN is undefined, tie OutportData to 0 and ignore OutportIn.

Verification
REQ-026 SHALL be verified by: MBIout=1, manualBusInput=0, PCin=MARin=1 -> PC=0, MAR=0.
REQ-027 SHALL be verified by: PC=0, PCout=1, OpCode=12, Zin=1 -> Z=1; then Zlowout=1, PCin=1 -> PC=1.
REQ-028 SHALL be verified by: RAM[0]=0x12000090, MAR=0, Read=1, MDRin=1, then MDRout=1, IRin=1 -> IR=0x12000090; Gra=1, MBIout=1 with 0x67, Rin=1 -> R4=0x67.
REQ-029 SHALL be verified by: IR=0x12000090, Grb=1, BAout=1, Yin=1 -> Y=0 (R0 forced); Cout=1, OpCode=2, Zin=1 -> Z=0x90.
REQ-030 SHALL be verified by: MAR=0x90, MDR=0x67, Write=1 -> RAM[0x90]=0x67; then Read=1, MDRin=1 -> MDR=0x67.
REQ-031 SHALL be verified by: IR[20:19]=11, bus=0x80000000, CONin=1 -> CON=1; asserting clr mid-cycle -> all registers 0 before the next edge.

Source files
------------

// File: rtl/datapath2.sv
// datapath2: single-bus processor datapath. It holds PC, IR, MAR, MDR, Y, Z,
// sixteen general registers R0-R15, a CON branch flag, an ALU and a 512x32 RAM.
// The output port register is built only when DATAPATH2_OUTPORT_EN is defined.
// Without that macro, OutportData is tied to zero and OutportIn is ignored.
module datapath2 (
   input  logic        clk,
   input  logic        clr,
   input  logic        PCin,
   input  logic        IRin,
   input  logic        MARin,
   input  logic        MDRin,
   input  logic        Yin,
   input  logic        Zin,
   input  logic        Rin,
   input  logic        CONin,
   input  logic        OutportIn,
   input  logic        PCout,
   input  logic        Zlowout,
   input  logic        MDRout,
   input  logic        MBIout,
   input  logic        Rout,
   input  logic        BAout,
   input  logic        Cout,
   input  logic        Gra,
   input  logic        Grb,
   input  logic        Grc,
   input  logic        Read,
   input  logic        Write,
   input  logic [4:0]  OpCode,
   input  logic [31:0] manualBusInput,
   output logic [31:0] BusMuxOut,
   output logic        CON,
   output logic [31:0] OutportData
);

   logic [31:0] pc, ir, mar, mdr, y, z;
   logic [31:0] regs [16];
   logic        con_q;
   logic [31:0] ram [512];

   logic [31:0] bus, alu, c_ext, ram_rd;
   logic [3:0]  ra, rb, rc, r_sel;
   logic [4:0]  sh;
   logic [63:0] rot_r, rot_l;
   logic        con_next;
   logic        unused_bits;

   assign ra     = ir[26:23];
   assign rb     = ir[22:19];
   assign rc     = ir[18:15];
   assign c_ext  = {{13{ir[18]}}, ir[18:0]};
   assign r_sel  = ({4{Gra}} & ra) | ({4{Grb}} & rb) | ({4{Grc}} & rc);
   assign ram_rd = ram[mar[8:0]];

   // Bus source selection, highest priority first; an idle bus reads as zero.
   // BAout is the base-address path, so R0 reads as zero there.
   always_comb begin
      bus = '0;
      if (MBIout)
         bus = manualBusInput;
      else if (MDRout)
         bus = mdr;
      else if (PCout)
         bus = pc;
      else if (Zlowout)
         bus = z;
      else if (Cout)
         bus = c_ext;
      else if (Rout)
         bus = regs[r_sel];
      else if (BAout)
         bus = (r_sel == 4'd0) ? 32'd0 : regs[r_sel];
   end

   assign BusMuxOut = bus;

   // A rotate is read out of a 64-bit double copy of Y shifted by B[4:0].
   assign sh    = bus[4:0];
   assign rot_r = {y, y} >> sh;
   assign rot_l = {y, y} << sh;

   // ALU: A comes from Y and B comes from the bus.
   always_comb begin
      alu = '0;
      case (OpCode)
         5'd2:    alu = y + bus;
         5'd3:    alu = y - bus;
         5'd4:    alu = y & bus;
         5'd5:    alu = y | bus;
         5'd6:    alu = y >> sh;
         5'd7:    alu = y << sh;
         5'd8:    alu = rot_r[31:0];
         5'd9:    alu = rot_l[63:32];
         5'd10:   alu = 32'd0 - bus;
         5'd11:   alu = ~bus;
         5'd12:   alu = bus + 32'd1;
         default: alu = '0;
      endcase
   end

   // Branch condition on the bus, chosen by IR[20:19].
   always_comb begin
      con_next = 1'b0;
      case (ir[20:19])
         2'b00: con_next = (bus == 32'd0);
         2'b01: con_next = (bus != 32'd0);
         2'b10: con_next = ~bus[31] && (bus != 32'd0);
         2'b11: con_next = bus[31];
         default: con_next = 1'b0;
      endcase
   end

   // Register updates from the bus, the ALU or the RAM.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         pc    <= '0;
         ir    <= '0;
         mar   <= '0;
         mdr   <= '0;
         y     <= '0;
         z     <= '0;
         con_q <= 1'b0;
         for (int i = 0; i < 16; i++)
            regs[i] <= '0;
      end else begin
         if (PCin)  pc  <= bus;
         if (IRin)  ir  <= bus;
         if (MARin) mar <= bus;
         if (MDRin) mdr <= Read ? ram_rd : bus;
         if (Yin)   y   <= bus;
         if (Zin)   z   <= alu;
         if (CONin) con_q <= con_next;
         if (Rin)   regs[r_sel] <= bus;
      end
   end

   // RAM write. It is never reset, and it stores the MDR value from before
   // the clock edge.
   always_ff @(posedge clk) begin
      if (Write)
         ram[mar[8:0]] <= mdr;
   end

   assign CON = con_q;

`ifdef DATAPATH2_OUTPORT_EN
   logic [31:0] outport_q;

   // Output port register, loaded from the bus.
   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         outport_q <= '0;
      else if (OutportIn)
         outport_q <= bus;
   end

   assign OutportData = outport_q;
   assign unused_bits = ^{ir[31:27], mar[31:9], rot_r[63:32], rot_l[31:0]};
`else
   assign OutportData = '0;
   assign unused_bits = ^{ir[31:27], mar[31:9], rot_r[63:32], rot_l[31:0], OutportIn};
`endif

endmodule

// File: tb/tb_datapath2.sv
// tb_datapath2: directed and randomized checks of datapath2 against an
// arithmetic reference model held in the bench.
module tb_datapath2;
   logic        clk = 1'b0;
   logic        clr;
   logic        PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin, OutportIn;
   logic        PCout, Zlowout, MDRout, MBIout, Rout, BAout, Cout;
   logic        Gra, Grb, Grc, Read, Write;
   logic [4:0]  OpCode;
   logic [31:0] manualBusInput;
   logic [31:0] BusMuxOut, OutportData;
   logic        CON;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_r [16];

   always #5 clk = ~clk;

   datapath2 dut (
      .clk(clk), .clr(clr),
      .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
      .Zin(Zin), .Rin(Rin), .CONin(CONin), .OutportIn(OutportIn),
      .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MBIout(MBIout),
      .Rout(Rout), .BAout(BAout), .Cout(Cout),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Read(Read), .Write(Write),
      .OpCode(OpCode), .manualBusInput(manualBusInput),
      .BusMuxOut(BusMuxOut), .CON(CON), .OutportData(OutportData)
   );

   function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
      int s;
      s = int'(b[4:0]);
      case (op)
         2:  return a + b;
         3:  return a - b;
         4:  return a & b;
         5:  return a | b;
         6:  return a >> s;
         7:  return a << s;
         8:  return (a >> s) | (a << (32 - s));
         9:  return (a << s) | (a >> (32 - s));
         10: return 32'd0 - b;
         11: return ~b;
         12: return b + 32'd1;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic ref_con(input int cc, input logic [31:0] b);
      case (cc)
         0: return b == 32'd0;
         1: return b != 32'd0;
         2: return $signed(b) > 0;
         default: return $signed(b) < 0;
      endcase
   endfunction

   function automatic logic [31:0] ref_sext(input logic [31:0] v);
      logic signed [18:0] c;
      logic signed [31:0] r;
      c = v[18:0];
      r = c;
      return r;
   endfunction

   task automatic clear_ctl();
      {PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin, OutportIn} = '0;
      {PCout, Zlowout, MDRout, MBIout, Rout, BAout, Cout} = '0;
      {Gra, Grb, Grc, Read, Write} = '0;
      OpCode = '0;
      manualBusInput = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      clear_ctl();
   endtask

   task automatic mbi(input logic [31:0] v);
      MBIout = 1'b1;
      manualBusInput = v;
   endtask

   // src: 0 PC, 1 Z, 2 MDR, 3 C
   task automatic peek(input int src, output logic [31:0] v);
      case (src)
         0: PCout = 1'b1;
         1: Zlowout = 1'b1;
         2: MDRout = 1'b1;
         default: Cout = 1'b1;
      endcase
      #1;
      v = BusMuxOut;
      {PCout, Zlowout, MDRout, Cout} = '0;
   endtask

   task automatic peek_reg(input logic [2:0] g, input bit ba, output logic [31:0] v);
      {Grc, Grb, Gra} = g;
      if (ba) BAout = 1'b1; else Rout = 1'b1;
      #1;
      v = BusMuxOut;
      {Grc, Grb, Gra, Rout, BAout} = '0;
   endtask

   task automatic set_ir(input logic [31:0] v);
      mbi(v);
      IRin = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      logic [31:0] v;
      clear_ctl();
      clr = 1'b1;
      #11;
      n_tests++; if (CON !== 1'b0) begin n_fail++; $display("FAIL reset_con got %b want 0", CON); end
      n_tests++; if (OutportData !== 32'd0) begin n_fail++; $display("FAIL reset_outport got %h want 0", OutportData); end
      peek(0, v);
      n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_pc got %h want 0", v); end
      clr = 1'b0;
      peek(1, v);
      n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_z got %h want 0", v); end
      #1;
      n_tests++; if (BusMuxOut !== 32'd0) begin n_fail++; $display("FAIL idle_bus got %h want 0", BusMuxOut); end
      for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
      mbi(32'h0000_1234);
      PCin = 1'b1;
      tick();
      peek(0, v);
      n_tests++; if (v !== 32'h0000_1234) begin n_fail++; $display("FAIL first_edge_pc got %h want 00001234", v); end
   endtask

   task automatic test_req026();
      logic [31:0] v;
      // RAM[0] = 0x12000090 and RAM[5] = 0x5555, so MAR becomes observable.
      mbi(32'd0); MARin = 1'b1; tick();
      mbi(32'h1200_0090); MDRin = 1'b1; tick();
      Write = 1'b1; tick();
      mbi(32'd5); MARin = 1'b1; tick();
      mbi(32'h0000_5555); MDRin = 1'b1; tick();
      Write = 1'b1; tick();
      mbi(32'd0); PCin = 1'b1; MARin = 1'b1; tick();
      peek(0, v);
      n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL req026_pc got %h want 0", v); end
   endtask

   task automatic test_req027();
      logic [31:0] v;
      PCout = 1'b1; OpCode = 5'd12; Zin = 1'b1; tick();
      peek(1, v);
      n_tests++; if (v !== 32'd1) begin n_fail++; $display("FAIL req027_z got %h want 1", v); end
      Zlowout = 1'b1; PCin = 1'b1; tick();
      peek(0, v);
      n_tests++; if (v !== 32'd1) begin n_fail++; $display("FAIL req027_pc got %h want 1", v); end
   endtask

   task automatic test_req028();
      logic [31:0] v;
      Read = 1'b1; MDRin = 1'b1; tick();
      peek(2, v);
      n_tests++; if (v !== 32'h1200_0090) begin n_fail++; $display("FAIL req028_mdr_mar0 got %h want 12000090", v); end
      MDRout = 1'b1; IRin = 1'b1; tick();
      peek(3, v);
      n_tests++; if (v !== 32'h0000_0090) begin n_fail++; $display("FAIL req028_ir_c got %h want 00000090", v); end
      Gra = 1'b1; mbi(32'h67); Rin = 1'b1; tick();
      m_r[4] = 32'h67;
      peek_reg(3'b001, 1'b0, v);
      n_tests++; if (v !== 32'h67) begin n_fail++; $display("FAIL req028_r4 got %h want 00000067", v); end
   endtask

   task automatic test_req029();
      logic [31:0] v;
      Grb = 1'b1; mbi(32'h0000_DEAD); Rin = 1'b1; tick();
      m_r[0] = 32'h0000_DEAD;
      peek_reg(3'b010, 1'b0, v);
      n_tests++; if (v !== 32'h0000_DEAD) begin n_fail++; $display("FAIL req029_r0_rout got %h want 0000dead", v); end
      peek_reg(3'b010, 1'b1, v);
      n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL req029_r0_baout got %h want 0", v); end
      Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; tick();
      Cout = 1'b1; OpCode = 5'd2; Zin = 1'b1; tick();
      peek(1, v);
      n_tests++; if (v !== 32'h90) begin n_fail++; $display("FAIL req029_z got %h want 00000090", v); end
   endtask

   task automatic test_req030();
      logic [31:0] v;
      mbi(32'h90); MARin = 1'b1; tick();
      mbi(32'h67); MDRin = 1'b1; tick();
      Write = 1'b1; tick();
      mbi(32'd0); MDRin = 1'b1; tick();
      Read = 1'b1; MDRin = 1'b1; tick();
      peek(2, v);
      n_tests++; if (v !== 32'h67) begin n_fail++; $display("FAIL req030_readback got %h want 00000067", v); end
      mbi(32'h91); MARin = 1'b1; tick();
      mbi(32'h2222); MDRin = 1'b1; tick();
      mbi(32'h3333); MDRin = 1'b1; Write = 1'b1; tick();
      peek(2, v);
      n_tests++; if (v !== 32'h3333) begin n_fail++; $display("FAIL mdr_write_same_edge got %h want 00003333", v); end
      Read = 1'b1; MDRin = 1'b1; tick();
      peek(2, v);
      n_tests++; if (v !== 32'h2222) begin n_fail++; $display("FAIL ram_pre_edge_mdr got %h want 00002222", v); end
   endtask

   task automatic test_req031();
      logic [31:0] v;
      set_ir(32'h0018_0000);
      mbi(32'h8000_0000); CONin = 1'b1; tick();
      n_tests++; if (CON !== 1'b1) begin n_fail++; $display("FAIL req031_con got %b want 1", CON); end
      mbi(32'h0000_ABCD); PCin = 1'b1; tick();
      @(posedge clk);
      #3;
      clr = 1'b1;
      #1;
      n_tests++; if (CON !== 1'b0) begin n_fail++; $display("FAIL async_clr_con got %b want 0", CON); end
      peek(0, v);
      n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL async_clr_pc got %h want 0", v); end
      peek(2, v);
      n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL async_clr_mdr got %h want 0", v); end
      peek(1, v);
      n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL async_clr_z got %h want 0", v); end
      clr = 1'b0;
      for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
      set_ir(32'h0200_0000);
      peek_reg(3'b001, 1'b0, v);
      n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL async_clr_r4 got %h want 0", v); end
      Read = 1'b1; MDRin = 1'b1; tick();
      peek(2, v);
      n_tests++; if (v !== 32'h1200_0090) begin n_fail++; $display("FAIL ram_kept_after_clr got %h want 12000090", v); end
   endtask

   task automatic test_con_random();
      int          cc, pick;
      logic [31:0] b, irv;
      for (int i = 0; i < 24; i++) begin
         cc   = $urandom_range(3, 0);
         pick = $urandom_range(4, 0);
         case (pick)
            0: b = 32'd0;
            1: b = 32'd1;
            2: b = 32'h8000_0000;
            3: b = 32'h7FFF_FFFF;
            default: b = $urandom;
         endcase
         irv = ($urandom & ~32'h0018_0000) | (32'(cc) << 19);
         set_ir(irv);
         mbi(b); CONin = 1'b1; tick();
         n_tests++;
         if (CON !== ref_con(cc, b)) begin
            n_fail++;
            $display("FAIL con cc=%0d bus=%h got %b want %b", cc, b, CON, ref_con(cc, b));
         end
      end
   endtask

   task automatic test_alu_random();
      int          op;
      logic [31:0] a, b, v;
      for (int i = 0; i < 40; i++) begin
         op = (i < 26) ? 2 + (i % 11) : int'($urandom_range(31, 0));
         a  = $urandom;
         b  = $urandom;
         mbi(a); Yin = 1'b1; tick();
         mbi(b); OpCode = 5'(op); Zin = 1'b1; tick();
         peek(1, v);
         n_tests++;
         if (v !== ref_alu(op, a, b)) begin
            n_fail++;
            $display("FAIL alu op=%0d a=%h b=%h got %h want %h", op, a, b, v, ref_alu(op, a, b));
         end
      end
   endtask

   task automatic test_regfile_random();
      logic [3:0]  f [3];
      logic [3:0]  idx;
      logic [2:0]  g;
      logic [31:0] v, w, want;
      int          sel;
      for (int i = 0; i < 20; i++) begin
         for (int k = 0; k < 3; k++) f[k] = 4'($urandom_range(15, 0));
         set_ir({5'd0, f[0], f[1], f[2], 15'($urandom)});
         sel = $urandom_range(2, 0);
         v   = $urandom;
         {Grc, Grb, Gra} = 3'b001 << sel;
         mbi(v); Rin = 1'b1; tick();
         m_r[f[sel]] = v;
         g   = 3'($urandom_range(7, 1));
         idx = (g[0] ? f[0] : 4'd0) | (g[1] ? f[1] : 4'd0) | (g[2] ? f[2] : 4'd0);
         peek_reg(g, 1'b0, w);
         n_tests++;
         if (w !== m_r[idx]) begin
            n_fail++;
            $display("FAIL rout g=%b idx=%0d got %h want %h", g, idx, w, m_r[idx]);
         end
         want = (idx == 4'd0) ? 32'd0 : m_r[idx];
         peek_reg(g, 1'b1, w);
         n_tests++;
         if (w !== want) begin
            n_fail++;
            $display("FAIL baout g=%b idx=%0d got %h want %h", g, idx, w, want);
         end
      end
   endtask

   task automatic test_priority();
      logic [31:0] pcv, mdrv, zv, irv, rv, mv, want;
      logic [5:0]  m;
      for (int i = 0; i < 30; i++) begin
         pcv = $urandom; mdrv = $urandom; zv = $urandom; irv = $urandom;
         rv = $urandom; mv = $urandom;
         mbi(pcv); PCin = 1'b1; tick();
         mbi(mdrv); MDRin = 1'b1; tick();
         mbi(zv); OpCode = 5'd11; Zin = 1'b1; tick();
         set_ir(irv);
         Gra = 1'b1; mbi(rv); Rin = 1'b1; tick();
         m_r[irv[26:23]] = rv;
         m = 6'($urandom_range(63, 0));
         if (m[0])      want = mv;
         else if (m[1]) want = mdrv;
         else if (m[2]) want = pcv;
         else if (m[3]) want = ~zv;
         else if (m[4]) want = ref_sext(irv);
         else if (m[5]) want = rv;
         else           want = 32'd0;
         {Rout, Cout, Zlowout, PCout, MDRout, MBIout} = m;
         manualBusInput = mv;
         Gra = 1'b1;
         #1;
         n_tests++;
         if (BusMuxOut !== want) begin
            n_fail++;
            $display("FAIL bus_priority sel=%b got %h want %h", m, BusMuxOut, want);
         end
         clear_ctl();
      end
   endtask

   task automatic test_outport();
      logic [31:0] v;
      v = $urandom | 32'h1;
      mbi(v); OutportIn = 1'b1; tick();
`ifdef DATAPATH2_OUTPORT_EN
      n_tests++; if (OutportData !== v) begin n_fail++; $display("FAIL outport got %h want %h", OutportData, v); end
`else
      n_tests++; if (OutportData !== 32'd0) begin n_fail++; $display("FAIL outport_tied got %h want 0", OutportData); end
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_req026();
      test_req027();
      test_req028();
      test_req029();
      test_req030();
      test_req031();
      test_con_random();
      test_alu_random();
      test_regfile_random();
      test_priority();
      test_outport();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
